// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine datapath: phase codes shown on
// the display, mode encodings used by the pre, scheduler and billing stages,
// and the per-mode water target / wash / spin duration tables.
// -----------------------------------------------------------------------------
package wash_pkg;

    // Phase codes as they appear on the phase display. Codes 6 and 7 are unused.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5
    } phase_e;

    // Wash modes, shared with the pre (selection/payment) and billing stages.
    typedef enum logic [1:0] {
        MODE_DRY    = 2'd0,
        MODE_SMALL  = 2'd1,
        MODE_MEDIUM = 2'd2,
        MODE_BIG    = 2'd3
    } mode_e;

    localparam int NUM_MODES = 4;

    // Per-mode tables, indexed by mode code (dry, small, medium, big).
    // Water target is in lights; wash and spin durations are in seconds.
    localparam logic [7:0] WATER_TARGET [NUM_MODES] = '{8'd0, 8'd3, 8'd5, 8'd8};
    localparam logic [7:0] WASH_SECS    [NUM_MODES] = '{8'd0, 8'd4, 8'd6, 8'd8};
    localparam logic [7:0] SPIN_SECS    [NUM_MODES] = '{8'd5, 8'd3, 8'd3, 8'd3};

    // Number of lit lights in a thermometer-coded level; one drain second
    // is needed per light.
    function automatic logic [7:0] light_count(input logic [7:0] lv);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {7'd0, lv[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/wash_sched_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// One-second prescaler. Counts 0..TICK_DIV-1 while enabled and asserts tick
// for one cycle on the terminal count. Holds its count while disabled.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   count enable (machine busy and not paused)
//   clr   in   restart the count from zero (start accepted)
//   tick  out  one-cycle pulse on the terminal count
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Decoded straight from the count register so the scheduler sees the
    // tick in the same cycle the count sits at its terminal value.
    assign tick = en && (cnt == TERM);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wash_sched.sv
// -----------------------------------------------------------------------------
// wash_sched
// Phase sequencer for the washing machine. A start pulse latches the mode and
// walks the machine through FILL, WASH, DRAIN and SPIN (dry mode goes straight
// to SPIN), counting down whole seconds from a prescaler, then emits a single
// done pulse to hand over to billing.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   one-cycle start pulse, accepted only when idle
//   pause     in   one-cycle pulse, toggles pause while running
//   mode      in   wash mode, sampled when a start is accepted
//   phase     out  current phase code (see wash_pkg::phase_e)
//   remain    out  seconds left in the current phase
//   wt_level  out  water-level lights, thermometer coded from bit 0
//   busy      out  high whenever phase is not IDLE
//   paused    out  pause status
//   done      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module wash_sched
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic [7:0] wt_level,
    output logic       busy,
    output logic       paused,
    output logic       done
);

    phase_e     state;
    logic [1:0] mode_q;
    logic       tick;
    logic       start_ok;

    assign start_ok = start && !busy;
    assign phase    = state;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (busy && !paused),
        .clr  (start_ok),
        .tick (tick)
    );

    // NOTE: mode_q is only ever read while busy and is always written on the
    // accepted start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PH_IDLE;
            remain   <= '0;
            wt_level <= '0;
            busy     <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                PH_IDLE: begin
                    // Start beats a coincident pause: paused stays clear.
                    if (start) begin
                        busy <= 1'b1;
                        if (mode == MODE_DRY) begin
                            state  <= PH_SPIN;
                            remain <= SPIN_SECS[mode];
                        end else begin
                            state  <= PH_FILL;
                            remain <= WATER_TARGET[mode];
                        end
                    end
                end

                PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN: begin
                    if (tick) begin
                        remain <= remain - 8'd1;
                        if (state == PH_FILL) begin
                            wt_level <= {wt_level[6:0], 1'b1};
                        end
                        if (state == PH_DRAIN) begin
                            wt_level <= wt_level >> 1;
                        end
                        // Last second of the phase: the level update above
                        // still lands, but remain is reloaded for the next one.
                        if (remain == 8'd1) begin
                            unique case (state)
                                PH_FILL: begin
                                    state  <= PH_WASH;
                                    remain <= WASH_SECS[mode_q];
                                end
                                PH_WASH: begin
                                    state  <= PH_DRAIN;
                                    remain <= light_count(wt_level);
                                end
                                PH_DRAIN: begin
                                    state  <= PH_SPIN;
                                    remain <= SPIN_SECS[mode_q];
                                end
                                default: begin
                                    state <= PH_DONE;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                    // A pause on a tick cycle takes effect after the tick.
                    if (pause) begin
                        paused <= !paused;
                    end
                end

                PH_DONE: begin
                    state  <= PH_IDLE;
                    busy   <= 1'b0;
                    paused <= 1'b0;
                    done   <= 1'b0;
                end

                default: begin
                    // Unused codes recover to a clean idle machine.
                    state    <= PH_IDLE;
                    remain   <= '0;
                    wt_level <= '0;
                    busy     <= 1'b0;
                    paused   <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sched.sv
// -----------------------------------------------------------------------------
// tb_wash_sched
// Self-checking bench for wash_sched with TICK_DIV = 4. A behavioural model
// keeps the machine as a queue of pending phases, a seconds counter and an
// integer light count; every cycle all DUT outputs are compared against it.
// Directed scenarios add end-to-end latency and corner-case checks, followed
// by a randomized run.
// -----------------------------------------------------------------------------
module tb_wash_sched;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [7:0] remain;
    logic [7:0] wt_level;
    logic       busy;
    logic       paused;
    logic       done;

    wash_sched #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .mode     (mode),
        .phase    (phase),
        .remain   (remain),
        .wt_level (wt_level),
        .busy     (busy),
        .paused   (paused),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers: 0 idle, 1 fill, 2 wash, 3 drain, 4 spin, 5 done.
    int tgt_tab  [4] = '{0, 3, 5, 8};
    int wash_tab [4] = '{0, 4, 6, 8};
    int spin_tab [4] = '{5, 3, 3, 3};

    int m_q[$];
    int m_ph     = 0;
    int m_sec    = 0;
    int m_lights = 0;
    int m_pre    = 0;
    int m_tgt    = 0;
    int m_wash   = 0;
    int m_spin   = 0;
    bit m_paused = 1'b0;

    task automatic m_enter(input int ph);
        m_ph = ph;
        case (ph)
            1: m_sec = m_tgt;
            2: m_sec = m_wash;
            3: m_sec = m_lights;
            4: m_sec = m_spin;
            default: ;
        endcase
    endtask

    task automatic model_step(input logic s, input logic p, input logic [1:0] md, input logic r);
        bit tk;
        if (r) begin
            m_ph = 0; m_sec = 0; m_lights = 0; m_pre = 0; m_paused = 1'b0;
            m_q.delete();
        end else if (m_ph == 0) begin
            if (s) begin
                m_tgt  = tgt_tab[md];
                m_wash = wash_tab[md];
                m_spin = spin_tab[md];
                m_pre  = 0;
                if (md == 2'd0) m_q = '{4, 5};
                else            m_q = '{1, 2, 3, 4, 5};
                m_enter(m_q.pop_front());
            end
        end else if (m_ph == 5) begin
            m_ph = 0;
            m_paused = 1'b0;
        end else begin
            tk = 1'b0;
            if (!m_paused) begin
                if (m_pre == int'(TICK_DIV) - 1) begin
                    tk = 1'b1;
                    m_pre = 0;
                end else begin
                    m_pre++;
                end
            end
            if (tk) begin
                m_sec--;
                if (m_ph == 1) m_lights++;
                if (m_ph == 3) m_lights--;
                if (m_sec == 0) m_enter(m_q.pop_front());
            end
            if (p) m_paused = !m_paused;
        end
    endtask

    task automatic compare_all();
        check("phase",    {29'd0, phase},    m_ph);
        check("remain",   {24'd0, remain},   m_sec);
        check("wt_level", {24'd0, wt_level}, (1 << m_lights) - 1);
        check("busy",     {31'd0, busy},     (m_ph != 0) ? 1 : 0);
        check("paused",   {31'd0, paused},   {31'd0, m_paused});
        check("done",     {31'd0, done},     (m_ph == 5) ? 1 : 0);
    endtask

    // One clock: drive inputs, advance DUT and model together, compare away
    // from the active edge.
    task automatic step(input logic s, input logic p, input logic [1:0] md, input logic r);
        start = s; pause = p; mode = md; rst = r;
        @(posedge clk);
        model_step(s, p, md, r);
        cyc++;
        @(negedge clk);
        compare_all();
        start = 1'b0; pause = 1'b0; rst = 1'b0;
    endtask

    // Idle-steps until done is seen, then checks its latency from t_entry
    // and that the machine returns to idle.
    task automatic run_to_done(input string tag, input logic [1:0] md, input int t_entry, input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < exp_lat + 60 && !seen; i++) begin
            step(1'b0, 1'b0, md, 1'b0);
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 1);
        check({tag, "_latency"}, cyc - t_entry, exp_lat);
        step(1'b0, 1'b0, md, 1'b0);
        check({tag, "_back_idle"}, {29'd0, phase}, 0);
        check({tag, "_done_cleared"}, {31'd0, done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bit found;
        start = 1'b0; pause = 1'b0; mode = 2'd0; rst = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        check("rst_phase",  {29'd0, phase},    0);
        check("rst_remain", {24'd0, remain},   0);
        check("rst_level",  {24'd0, wt_level}, 0);
        check("rst_busy",   {31'd0, busy},     0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check("idle_pause_ignored", {31'd0, paused}, 0);

        // Mode 1: fill levels, wash load, 52-cycle run
        step(1'b1, 1'b0, 2'd1, 1'b0);
        t0 = cyc;
        check("m1_fill_phase",  {29'd0, phase},  1);
        check("m1_fill_remain", {24'd0, remain}, 3);
        repeat (4) step(1'b0, 1'b0, 2'd1, 1'b0);
        check("m1_lvl_t1", {24'd0, wt_level}, 8'h01);
        repeat (4) step(1'b0, 1'b0, 2'd1, 1'b0);
        check("m1_lvl_t2", {24'd0, wt_level}, 8'h03);
        repeat (4) step(1'b0, 1'b0, 2'd1, 1'b0);
        check("m1_lvl_t3",       {24'd0, wt_level}, 8'h07);
        check("m1_wash_phase",   {29'd0, phase},    2);
        check("m1_wash_remain",  {24'd0, remain},   4);
        run_to_done("m1", 2'd1, t0, 52);

        // Mode 0: straight to spin
        step(1'b1, 1'b0, 2'd0, 1'b0);
        t0 = cyc;
        check("m0_spin_phase",  {29'd0, phase},  4);
        check("m0_spin_remain", {24'd0, remain}, 5);
        run_to_done("m0", 2'd0, t0, 20);

        // Mode 3: pause for 40 cycles during wash at remain 5
        step(1'b1, 1'b0, 2'd3, 1'b0);
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == 2 && m_sec == 5) found = 1'b1;
            else step(1'b0, 1'b0, 2'd3, 1'b0);
        end
        check("m3_reach_wash5", {31'd0, found}, 1);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        check("m3_paused", {31'd0, paused}, 1);
        for (int i = 0; i < 39; i++) begin
            step(1'b0, 1'b0, 2'd3, 1'b0);
            check("m3_hold_remain", {24'd0, remain},   5);
            check("m3_hold_level",  {24'd0, wt_level}, 8'hFF);
        end
        step(1'b0, 1'b1, 2'd3, 1'b0);
        check("m3_resumed", {31'd0, paused}, 0);
        run_to_done("m3", 2'd3, t0, 148);

        // Mode 2: start pulse and mode change while busy are ignored
        step(1'b1, 1'b0, 2'd2, 1'b0);
        t0 = cyc;
        check("m2_fill_remain", {24'd0, remain}, 5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_ph == 2) found = 1'b1;
            else step(1'b0, 1'b0, 2'd3, 1'b0);
        end
        check("m2_reach_wash", {31'd0, found}, 1);
        check("m2_wash_remain", {24'd0, remain}, 6);
        step(1'b1, 1'b0, 2'd2, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        run_to_done("m2", 2'd0, t0, 76);

        // Reset while paused in drain, then a fresh run
        step(1'b1, 1'b0, 2'd1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_ph == 3) found = 1'b1;
            else step(1'b0, 1'b0, 2'd1, 1'b0);
        end
        check("rd_reach_drain", {31'd0, found}, 1);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b0, 2'd1, 1'b0);
        check("rd_paused_before", {31'd0, paused}, 1);
        step(1'b0, 1'b0, 2'd1, 1'b1);
        check("rd_phase",  {29'd0, phase},    0);
        check("rd_level",  {24'd0, wt_level}, 0);
        check("rd_remain", {24'd0, remain},   0);
        check("rd_paused", {31'd0, paused},   0);
        check("rd_busy",   {31'd0, busy},     0);
        step(1'b1, 1'b0, 2'd1, 1'b0);
        t0 = cyc;
        run_to_done("rd_fresh", 2'd1, t0, 52);

        // Start and pause together in idle
        step(1'b1, 1'b1, 2'd1, 1'b0);
        t0 = cyc;
        check("sp_phase",  {29'd0, phase},  1);
        check("sp_paused", {31'd0, paused}, 0);
        run_to_done("sp", 2'd1, t0, 52);

        // Pause coincident with the final fill tick
        step(1'b1, 1'b0, 2'd1, 1'b0);
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_ph == 1 && m_sec == 1 && m_pre == int'(TICK_DIV) - 1) found = 1'b1;
            else step(1'b0, 1'b0, 2'd1, 1'b0);
        end
        check("pt_reach_last_tick", {31'd0, found}, 1);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        check("pt_phase",  {29'd0, phase},  2);
        check("pt_paused", {31'd0, paused}, 1);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        run_to_done("pt", 2'd1, t0, 53);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(7) == 0), ($urandom_range(19) == 0),
                 2'($urandom_range(3)), ($urandom_range(299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wash_sched.md
# wash_sched

Phase sequencer for the washing-machine datapath. It runs between the pre (mode/payment) stage and the billing stage. After a start pulse it steps the machine through fill, wash, drain and spin, with per-mode durations and water targets. It drives the water-level lights and the phase/remaining-time values shown on the displays, and emits a single `done` pulse that hands control to billing.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clk cycles per one-second tick. Legal range is 2 and above.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse from a debounced button; begins a cycle.
- `pause`  in  1  one-cycle pulse; toggles pause while busy.
- `mode`  in  2  wash mode: 0 dry, 1 small, 2 medium, 3 big. Sampled only when a start is accepted.
- `phase`  out  3  current phase code.
- `remain`  out  8  seconds left in the current phase, unsigned binary.
- `wt_level`  out  8  water-level lights, thermometer coded from bit 0 upward.
- `busy`  out  1  high whenever `phase` is not IDLE.
- `paused`  out  1  pause status.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Phase codes:
  - IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, DONE=5.
  - Codes 6 and 7 are illegal; the FSM goes to IDLE from them.
- Per-mode constants, indexed by the latched mode (dry/small/medium/big):
  - Water target: 0/3/5/8 lights.
  - Wash duration: 0/4/6/8 s.
  - Spin duration: 5/3/3/3 s.
- Reset: `phase`=IDLE, `remain`=0, `wt_level`=0, `busy`=0, `paused`=0, `done`=0, prescaler=0.
- IDLE:
  - A start pulse latches `mode` and clears the prescaler.
  - Next phase is FILL for modes 1–3, or SPIN for mode 0.
- Entering a phase loads `remain` with that phase's duration:
  - FILL: the water target.
  - WASH: the wash duration.
  - DRAIN: the current light count.
  - SPIN: the spin duration.
- Each tick while busy and not paused:
  - `remain` decrements.
  - In FILL, `wt_level` becomes `{wt_level[6:0],1'b1}`.
  - In DRAIN, `wt_level` becomes `wt_level>>1`.
- On a tick with `remain`==1 the FSM moves to the next phase:
  - FILL→WASH→DRAIN→SPIN→DONE.
  - The decrement and level update from that tick still apply in the same cycle.
- DONE lasts exactly 1 cycle with `done`=1, then the FSM returns to IDLE.
- Pause:
  - Toggles `paused` only while busy and not in DONE.
  - While paused, the prescaler, `remain` and `wt_level` all hold.
- Ignored inputs:
  - `start` is ignored while busy.
  - `pause` is ignored in IDLE and DONE.
  - `mode` changes while busy have no effect.
- Leaving DONE or applying reset clears `paused`.

## Timing
- Start accepted in cycle N puts the new phase on `phase` in cycle N+1. `remain` is loaded in that same cycle.
- Ticks:
  - The prescaler counts 0..TICK_DIV-1 and ticks on the terminal count.
  - The first tick comes TICK_DIV cycles after phase entry from IDLE.
  - The prescaler is not cleared between phases.
- Phase changes and all output updates are registered and visible 1 cycle after the tick edge.
- End-to-end latency from FILL (or SPIN for mode 0) entry to DONE is (target + wash + target + spin) × TICK_DIV cycles.
- Simultaneous events:
  - `start` and `pause` together in IDLE: start wins and `paused` stays 0.
  - `pause` on a tick cycle: the tick is processed, then `paused` is set.
  - `rst` mid-cycle: IDLE on the next edge with all outputs at their reset values, regardless of `paused`.

## Structure
- Package `wash_pkg` holds:
  - The phase enum/localparams.
  - The per-mode target, wash and spin constant arrays.
  - Mode encodings shared with the pre and billing stages.
- Sub-module `tick_gen`:
  - Prescaler with `en` and `clr` inputs and a one-cycle `tick` output.
  - `en` = busy & ~paused; `clr` = start accepted.
- The FSM, `remain` counter and level shifter stay in `wash_sched`.

## Test plan
All directed tests use TICK_DIV=4.
- Mode 1 start:
  - FILL `remain`=3.
  - `wt_level` goes 0x01, 0x03, 0x07 at ticks 1–3.
  - WASH `remain`=4, DRAIN empties back to 0x00, SPIN `remain`=3.
  - `done` is high for one cycle, 52 cycles after FILL entry, then IDLE.
- Mode 0 start:
  - Goes straight to SPIN with `remain`=5 and `wt_level` staying 0.
  - `done` is high 20 cycles after SPIN entry.
- Mode 3, pause pulse during WASH with `remain`=5:
  - `remain`, `wt_level` (0xFF) and prescaler hold for 40 cycles.
  - A second pause resumes; total completion is delayed by exactly 40 cycles.
- Start pulse with mode=2 during WASH, and a mode change while busy:
  - No effect; the sequence completes with medium values (target 5, wash 6).
- `rst` asserted during DRAIN with `paused`=1:
  - Next cycle: IDLE, `wt_level`=0, `remain`=0, `paused`=0, `busy`=0.
  - A fresh start then runs normally.
- `pause` and `start` in the same IDLE cycle: FILL entered with `paused`=0.
- `pause` coincident with the FILL tick where `remain`==1: WASH entered with `paused`=1.
